// File: rtl/mac_acc_pipe.sv
// Pipelined INT8 / INT4 / INT4_VSQ dot-product accumulator with valid/ready on both sides.
// Optional MAC_SAT_FLAG_EN adds o_sat, a sticky per-packet saturation flag.
module mac_acc_pipe #(
  parameter int  LANES = 4,
  parameter int  ACC_W = 24,
  parameter int  SF_W  = 8,
  localparam int DW    = 8*LANES
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_last,
  input  logic [1:0]       i_mode,
  input  logic [DW-1:0]    i_a_data,
  input  logic [DW-1:0]    i_b_data,
  input  logic [SF_W-1:0]  i_a_sf,
  input  logic [SF_W-1:0]  i_b_sf,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [ACC_W-1:0] o_result
`ifdef MAC_SAT_FLAG_EN
  , output logic           o_sat
`endif
);
  // Mode encodings shared with the PE array
  localparam logic [1:0] MODE_INT4 = 2'd0;
  localparam logic [1:0] MODE_INT8 = 2'd1;
  localparam logic [1:0] MODE_VSQ  = 2'd2;

  localparam int L4 = 2*LANES;
  localparam int PW = 16 + $clog2(L4) + 2*SF_W + 2;
  localparam int SW = ((PW > ACC_W) ? PW : ACC_W) + 1;
  localparam logic signed [SW-1:0]    SMAX = SW'({(ACC_W-1){1'b1}});
  localparam logic signed [SW-1:0]    SMIN = -SMAX;
  localparam logic signed [ACC_W-1:0] AMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AMIN = -AMAX;

  logic signed [PW-1:0]     dot8_d, dot4_d, prod_d;
  logic signed [15:0]       p8_d;
  logic signed [7:0]        p4_d;
  logic [2*SF_W-1:0]        sfu_d;
  logic signed [2*SF_W:0]   sfs_d;

  logic                     s1_valid_q, s1_last_q;
  logic signed [PW-1:0]     s1_prod_q;
  logic signed [ACC_W-1:0]  acc_q, o_result_q, sat_d;
  logic signed [SW-1:0]     sum_d;
  logic                     o_valid_q, s1_fire, accept;

  always_comb begin
    dot8_d = '0;
    dot4_d = '0;
    p8_d   = '0;
    p4_d   = '0;
    for (int i = 0; i < LANES; i++) begin
      p8_d   = $signed(i_a_data[8*i +: 8]) * $signed(i_b_data[8*i +: 8]);
      dot8_d = dot8_d + PW'(p8_d);
    end
    for (int i = 0; i < L4; i++) begin
      p4_d   = $signed(i_a_data[4*i +: 4]) * $signed(i_b_data[4*i +: 4]);
      dot4_d = dot4_d + PW'(p4_d);
    end
    sfu_d = i_a_sf * i_b_sf;
    sfs_d = $signed({1'b0, sfu_d});
    case (i_mode)
      MODE_INT8: prod_d = dot8_d;
      MODE_INT4: prod_d = dot4_d;
      MODE_VSQ:  prod_d = dot4_d * PW'(sfs_d);
      default:   prod_d = '0;
    endcase
  end

  // A last beat may only leave S1 if the output register is free or being drained
  assign s1_fire = s1_valid_q && (!s1_last_q || !o_valid_q || i_ready);
  assign o_ready = i_rst_n && (!s1_valid_q || s1_fire);
  assign accept  = i_valid && o_ready;

  // Symmetric clamp: the most negative code is never produced
  always_comb begin
    sum_d = SW'(acc_q) + SW'(s1_prod_q);
    sat_d = sum_d[ACC_W-1:0];
    if (sum_d > SMAX)      sat_d = AMAX;
    else if (sum_d < SMIN) sat_d = AMIN;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_prod_q  <= '0;
      acc_q      <= '0;
      o_result_q <= '0;
      o_valid_q  <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_last_q  <= i_last;
        s1_prod_q  <= prod_d;
      end else if (s1_fire) begin
        s1_valid_q <= 1'b0;
      end
      if (s1_fire) begin
        if (s1_last_q) begin
          o_result_q <= sat_d;
          acc_q      <= '0;
        end else begin
          acc_q      <= sat_d;
        end
      end
      if (s1_fire && s1_last_q)       o_valid_q <= 1'b1;
      else if (o_valid_q && i_ready)  o_valid_q <= 1'b0;
    end
  end

  assign o_valid  = o_valid_q;
  assign o_result = o_result_q;

`ifdef MAC_SAT_FLAG_EN
  logic clamp_d, sat_acc_q, o_sat_q;
  assign clamp_d = (sum_d > SMAX) || (sum_d < SMIN);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sat_acc_q <= 1'b0;
      o_sat_q   <= 1'b0;
    end else if (s1_fire) begin
      if (s1_last_q) begin
        o_sat_q   <= sat_acc_q | clamp_d;
        sat_acc_q <= 1'b0;
      end else begin
        sat_acc_q <= sat_acc_q | clamp_d;
      end
    end
  end

  assign o_sat = o_sat_q;
`endif
endmodule

// File: tb/tb_mac_acc_pipe.sv
// Directed self-checking bench for mac_acc_pipe; expected values hand-computed.
module tb_mac_acc_pipe;
  localparam int LANES = 4;
  localparam int ACC_W = 24;
  localparam int SF_W  = 8;
  localparam int DW    = 8*LANES;
  localparam logic [1:0] M_INT4 = 2'd0;
  localparam logic [1:0] M_INT8 = 2'd1;
  localparam logic [1:0] M_VSQ  = 2'd2;

  logic             i_clk = 1'b0;
  logic             i_rst_n, i_valid, i_last, i_ready;
  logic             o_ready, o_valid;
  logic [1:0]       i_mode;
  logic [DW-1:0]    i_a_data, i_b_data;
  logic [SF_W-1:0]  i_a_sf, i_b_sf;
  logic [ACC_W-1:0] o_result;
`ifdef MAC_SAT_FLAG_EN
  logic             o_sat;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 i_clk = ~i_clk;

  mac_acc_pipe #(.LANES(LANES), .ACC_W(ACC_W), .SF_W(SF_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_last(i_last), .i_mode(i_mode), .i_a_data(i_a_data), .i_b_data(i_b_data),
    .i_a_sf(i_a_sf), .i_b_sf(i_b_sf), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result)
`ifdef MAC_SAT_FLAG_EN
    , .o_sat(o_sat)
`endif
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [SF_W-1:0] asf, input logic [SF_W-1:0] bsf, input logic last);
    int n = 0;
    i_valid = 1'b1; i_mode = m; i_a_data = a; i_b_data = b;
    i_a_sf = asf; i_b_sf = bsf; i_last = last;
    #1;
    while (!o_ready && n < 100) begin
      tick();
      n++;
    end
    if (!o_ready) begin
      nvec++; nerr++;
      $display("FAIL send_timeout: o_ready=%0b, required 1 within 100 cycles", o_ready);
    end
    tick();
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!o_valid && n < 400) begin
      tick();
      n++;
    end
    if (!o_valid) begin
      nvec++; nerr++;
      $display("FAIL %s_timeout: o_valid=%0b, required 1 within 400 cycles", tag, o_valid);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b0;
    i_mode = M_INT8; i_a_data = '0; i_b_data = '0; i_a_sf = '0; i_b_sf = '0;
    repeat (3) tick();
    nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid: got %b, expected 0", o_valid); end
    nvec++; if (o_result !== '0) begin nerr++; $display("FAIL rst_result: got %h, expected 000000", o_result); end
    nvec++; if (o_ready !== 1'b0) begin nerr++; $display("FAIL rst_ready: got %b, expected 0", o_ready); end
`ifdef MAC_SAT_FLAG_EN
    nvec++; if (o_sat !== 1'b0) begin nerr++; $display("FAIL rst_sat: got %b, expected 0", o_sat); end
`endif
    i_rst_n = 1'b1;
    #1;
    nvec++; if (o_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready_after: got %b, expected 1", o_ready); end
  endtask

  task automatic test_int8();
    i_ready = 1'b1;
    send(M_INT8, 32'h7F7F7F7F, 32'h7F7F7F7F, 8'd0, 8'd0, 1'b0);
    send(M_INT8, 32'h7F7F7F7F, 32'h7F7F7F7F, 8'd0, 8'd0, 1'b0);
    send(M_INT8, 32'h7F7F7F7F, 32'h7F7F7F7F, 8'd0, 8'd0, 1'b1);
    nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL int8_lat_t1: got %b, expected 0", o_valid); end
    tick();
    nvec++; if (o_valid !== 1'b1) begin nerr++; $display("FAIL int8_lat_t2: got %b, expected 1", o_valid); end
    nvec++; if (o_result !== 24'h02F40C) begin nerr++; $display("FAIL int8_result: got %h, expected 02f40c", o_result); end
`ifdef MAC_SAT_FLAG_EN
    nvec++; if (o_sat !== 1'b0) begin nerr++; $display("FAIL int8_sat: got %b, expected 0", o_sat); end
`endif
    tick();
    nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL int8_pulse: got %b, expected 0", o_valid); end
  endtask

  task automatic test_int4_vsq();
    i_ready = 1'b1;
    send(M_INT4, 32'h77777777, 32'hFFFFFFFF, 8'd0, 8'd0, 1'b1);
    wait_valid("int4");
    nvec++; if (o_result !== 24'hFFFFC8) begin nerr++; $display("FAIL int4_result: got %h, expected ffffc8", o_result); end
    tick();
    send(M_VSQ, 32'h11111111, 32'h22222222, 8'd3, 8'd5, 1'b1);
    wait_valid("vsq");
    nvec++; if (o_result !== 24'd240) begin nerr++; $display("FAIL vsq_result: got %0d, expected 240", o_result); end
    tick();
    send(M_INT4, 32'h11111111, 32'h22222222, 8'd3, 8'd5, 1'b1);
    wait_valid("int4b");
    nvec++; if (o_result !== 24'd16) begin nerr++; $display("FAIL int4_nosf_result: got %0d, expected 16", o_result); end
    tick();
    send(2'd3, 32'h7F7F7F7F, 32'h7F7F7F7F, 8'd3, 8'd5, 1'b1);
    wait_valid("mode3");
    nvec++; if (o_result !== 24'd0) begin nerr++; $display("FAIL mode3_result: got %0d, expected 0", o_result); end
    tick();
  endtask

  task automatic test_saturation();
    i_ready = 1'b1;
    for (int i = 0; i < 200; i++) send(M_INT8, 32'h80808080, 32'h80808080, 8'd0, 8'd0, i == 199);
    wait_valid("sat_pos");
    nvec++; if (o_result !== 24'h7FFFFF) begin nerr++; $display("FAIL sat_pos_result: got %h, expected 7fffff", o_result); end
`ifdef MAC_SAT_FLAG_EN
    nvec++; if (o_sat !== 1'b1) begin nerr++; $display("FAIL sat_pos_flag: got %b, expected 1", o_sat); end
`endif
    tick();
    for (int i = 0; i < 200; i++) send(M_INT8, 32'h80808080, 32'h7F7F7F7F, 8'd0, 8'd0, i == 199);
    wait_valid("sat_neg");
    nvec++; if (o_result !== 24'h800001) begin nerr++; $display("FAIL sat_neg_result: got %h, expected 800001", o_result); end
`ifdef MAC_SAT_FLAG_EN
    nvec++; if (o_sat !== 1'b1) begin nerr++; $display("FAIL sat_neg_flag: got %b, expected 1", o_sat); end
`endif
    tick();
    // accumulator and flag must restart clean after a clamped packet
    send(M_INT8, 32'h01010101, 32'h01010101, 8'd0, 8'd0, 1'b1);
    wait_valid("sat_after");
    nvec++; if (o_result !== 24'd4) begin nerr++; $display("FAIL sat_after_result: got %0d, expected 4", o_result); end
`ifdef MAC_SAT_FLAG_EN
    nvec++; if (o_sat !== 1'b0) begin nerr++; $display("FAIL sat_after_flag: got %b, expected 0", o_sat); end
`endif
    tick();
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0;
    send(M_INT8, 32'h01010101, 32'h01010101, 8'd0, 8'd0, 1'b1);
    wait_valid("bp1");
    nvec++; if (o_result !== 24'd4) begin nerr++; $display("FAIL bp_first_result: got %0d, expected 4", o_result); end
    send(M_INT8, 32'h02020202, 32'h02020202, 8'd0, 8'd0, 1'b1);
    nvec++; if (o_ready !== 1'b0) begin nerr++; $display("FAIL bp_ready_low: got %b, expected 0", o_ready); end
    nvec++; if (o_valid !== 1'b1) begin nerr++; $display("FAIL bp_valid_held: got %b, expected 1", o_valid); end
    tick();
    nvec++; if (o_result !== 24'd4) begin nerr++; $display("FAIL bp_result_held: got %0d, expected 4", o_result); end
    i_ready = 1'b1;
    #1;
    nvec++; if (o_ready !== 1'b1) begin nerr++; $display("FAIL bp_ready_release: got %b, expected 1", o_ready); end
    tick();
    nvec++; if (o_valid !== 1'b1) begin nerr++; $display("FAIL bp_swap_valid: got %b, expected 1", o_valid); end
    nvec++; if (o_result !== 24'd16) begin nerr++; $display("FAIL bp_swap_result: got %0d, expected 16", o_result); end
    tick();
    nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL bp_drained: got %b, expected 0", o_valid); end
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b1;
    send(M_INT8, 32'h01010101, 32'h01010101, 8'd0, 8'd0, 1'b0);
    send(M_INT4, 32'h11111111, 32'h11111111, 8'd0, 8'd0, 1'b1);
    send(M_INT8, 32'h03030303, 32'h03030303, 8'd0, 8'd0, 1'b1);
    nvec++; if (o_valid !== 1'b1) begin nerr++; $display("FAIL b2b_valid1: got %b, expected 1", o_valid); end
    nvec++; if (o_result !== 24'd12) begin nerr++; $display("FAIL b2b_result1: got %0d, expected 12", o_result); end
    tick();
    nvec++; if (o_valid !== 1'b1) begin nerr++; $display("FAIL b2b_valid2: got %b, expected 1", o_valid); end
    nvec++; if (o_result !== 24'd36) begin nerr++; $display("FAIL b2b_result2: got %0d, expected 36", o_result); end
    tick();
    nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL b2b_end: got %b, expected 0", o_valid); end
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b1;
    send(M_INT8, 32'h7F7F7F7F, 32'h7F7F7F7F, 8'd0, 8'd0, 1'b0);
    send(M_INT8, 32'h7F7F7F7F, 32'h7F7F7F7F, 8'd0, 8'd0, 1'b0);
    i_rst_n = 1'b0;
    tick();
    nvec++; if (o_ready !== 1'b0) begin nerr++; $display("FAIL midrst_ready: got %b, expected 0", o_ready); end
    nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL midrst_valid: got %b, expected 0", o_valid); end
    i_rst_n = 1'b1;
    send(M_INT8, 32'h01010101, 32'h01010101, 8'd0, 8'd0, 1'b1);
    wait_valid("midrst");
    nvec++; if (o_result !== 24'd4) begin nerr++; $display("FAIL midrst_result: got %0d, expected 4", o_result); end
    tick();
  endtask

  initial begin
    test_reset();
    test_int8();
    test_int4_vsq();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
